// File: rtl/ula_seq.sv
// ula_seq: registered N-bit ALU with a start/busy/done handshake and status flags.
// Optional feature macro: ULA_MUL_EN. When defined, code 110 runs a WIDTH-cycle shift-add
// multiplier. When undefined, code 110 completes in one cycle and raises op_invalida.
module ula_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       seletor,
  output logic [WIDTH-1:0] resultado,
  output logic [WIDTH-1:0] resultado_alto,
  output logic             zero,
  output logic             negativo,
  output logic             carry,
  output logic             overflow,
  output logic             op_invalida,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
`ifdef ULA_MUL_EN
  localparam logic [1:0] StMul  = 2'd2;
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       sel_q, sel_d;
  logic [WIDTH-1:0] res_q, res_d, res_hi_q, res_hi_d;
  logic             zero_q, zero_d, neg_q, neg_d, carry_q, carry_d;
  logic             ovf_q, ovf_d, inv_q, inv_d, done_q, done_d;

  logic [WIDTH-1:0] calc_res;
  logic             calc_carry, calc_ovf, calc_inv;
  logic [WIDTH:0]   sum_ext, diff_ext;

`ifdef ULA_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_d, mul_step;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]     mul_sum;

  // One shift-add iteration: add A to the upper half when the current multiplier bit is set,
  // then shift the whole accumulator right, consuming one multiplier bit.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_step = {mul_sum, acc_q[WIDTH-1:1]};
  end
`endif

  // Single-cycle result and flags from the latched operands.
  always_comb begin
    sum_ext    = {1'b0, a_q} + {1'b0, b_q};
    diff_ext   = {1'b0, a_q} - {1'b0, b_q};
    calc_res   = '0;
    calc_carry = 1'b0;
    calc_ovf   = 1'b0;
    calc_inv   = 1'b0;
    case (sel_q)
      3'b000: calc_res = a_q & b_q;
      3'b001: calc_res = a_q | b_q;
      3'b010: calc_res = ~a_q;
      3'b011: calc_res = ~(a_q & b_q);
      3'b100: begin
        calc_res   = sum_ext[WIDTH-1:0];
        calc_carry = sum_ext[WIDTH];
        calc_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_ext[WIDTH-1] != a_q[WIDTH-1]);
      end
      3'b101: begin
        calc_res   = diff_ext[WIDTH-1:0];
        calc_carry = diff_ext[WIDTH];  // borrow: A < B unsigned
        calc_ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_ext[WIDTH-1] != a_q[WIDTH-1]);
      end
      3'b111: calc_res = a_q ^ b_q;
      default: calc_inv = 1'b1;  // 110 only reaches here with the multiplier compiled out
    endcase
  end

  // Next-state: handshake FSM, operand capture and output update on completion.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    inv_d    = inv_q;
    done_d   = 1'b0;
`ifdef ULA_MUL_EN
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          sel_d   = seletor;
          state_d = StCalc;
`ifdef ULA_MUL_EN
          if (seletor == 3'b110) begin
            state_d = StMul;
            acc_d   = {{WIDTH{1'b0}}, B};
            cnt_d   = '0;
          end
`endif
        end
      end
      StCalc: begin
        res_d    = calc_res;
        res_hi_d = '0;
        zero_d   = (calc_res == '0);
        neg_d    = calc_res[WIDTH-1];
        carry_d  = calc_carry;
        ovf_d    = calc_ovf;
        inv_d    = calc_inv;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
`ifdef ULA_MUL_EN
      StMul: begin
        acc_d = mul_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          res_d    = mul_step[WIDTH-1:0];
          res_hi_d = mul_step[2*WIDTH-1:WIDTH];
          zero_d   = (mul_step == '0);
          neg_d    = mul_step[WIDTH-1];
          carry_d  = (mul_step[2*WIDTH-1:WIDTH] != '0);
          ovf_d    = 1'b0;
          inv_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      inv_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef ULA_MUL_EN
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      inv_q    <= inv_d;
      done_q   <= done_d;
`ifdef ULA_MUL_EN
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign resultado      = res_q;
  assign resultado_alto = res_hi_q;
  assign zero           = zero_q;
  assign negativo       = neg_q;
  assign carry          = carry_q;
  assign overflow       = ovf_q;
  assign op_invalida    = inv_q;
  assign busy           = (state_q != StIdle);
  assign done           = done_q;

endmodule

// File: tb/tb_ula_seq.sv
// Directed self-checking bench for ula_seq at WIDTH=4; adapts MUL checks to ULA_MUL_EN.
module tb_ula_seq;

  logic       clk, rst, start;
  logic [3:0] A, B;
  logic [2:0] seletor;
  logic [3:0] resultado, resultado_alto;
  logic       zero, negativo, carry, overflow, op_invalida, busy, done;

  int checks = 0;
  int fails  = 0;

  ula_seq #(.WIDTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .A             (A),
    .B             (B),
    .seletor       (seletor),
    .resultado     (resultado),
    .resultado_alto(resultado_alto),
    .zero          (zero),
    .negativo      (negativo),
    .carry         (carry),
    .overflow      (overflow),
    .op_invalida   (op_invalida),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation and count cycles from the accepting edge to done (-1 on timeout).
  // Operand inputs are scrambled right after acceptance to show they are latched.
  task automatic run_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        output int lat, output logic busy_acc);
    @(negedge clk);
    seletor = op; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; busy_acc = busy;
    A = ~a; B = ~b; seletor = ~op;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A = '0; B = '0; seletor = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({resultado, resultado_alto} !== 8'h00) begin fails++;
      $display("FAIL reset_res: got %h want 00", {resultado, resultado_alto}); end
    checks++; if ({zero, negativo, carry, overflow, op_invalida, busy, done} !== 7'b0) begin
      fails++; $display("FAIL reset_flags: got %b want 0000000",
                        {zero, negativo, carry, overflow, op_invalida, busy, done}); end
    // start and rst on the same edge: reset wins
    @(negedge clk); start = 1'b1; seletor = 3'b100; A = 4'h3; B = 4'h4;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin fails++;
      $display("FAIL reset_vs_start_busy: got %b want 0", busy); end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    checks++; if ({busy, done} !== 2'b00) begin fails++;
      $display("FAIL reset_vs_start_done: got busy/done %b want 00", {busy, done}); end
  endtask

  task automatic test_soma_sub();
    int lat; logic ba;
    run_op(3'b100, 4'b1010, 4'b0110, lat, ba);
    checks++; if (ba !== 1'b1) begin fails++; $display("FAIL soma_busy: got %b want 1", ba); end
    checks++; if (lat != 1) begin fails++; $display("FAIL soma_latency: got %0d want 1", lat); end
    checks++; if (busy !== 1'b0) begin fails++;
      $display("FAIL soma_busy_in_done: got %b want 0", busy); end
    checks++; if ({resultado, carry, zero, overflow, negativo} !== 8'b0000_1100) begin fails++;
      $display("FAIL soma: got res/c/z/v/n %b want 00001100",
               {resultado, carry, zero, overflow, negativo}); end
    run_op(3'b101, 4'b1010, 4'b0110, lat, ba);
    checks++; if (lat != 1) begin fails++; $display("FAIL sub_latency: got %0d want 1", lat); end
    checks++; if ({resultado, carry, zero, overflow, negativo} !== 8'b0100_0010) begin fails++;
      $display("FAIL sub1: got res/c/z/v/n %b want 01000010",
               {resultado, carry, zero, overflow, negativo}); end
    run_op(3'b101, 4'b0011, 4'b1101, lat, ba);
    checks++; if ({resultado, carry, zero, overflow, negativo} !== 8'b0110_1000) begin fails++;
      $display("FAIL sub2: got res/c/z/v/n %b want 01101000",
               {resultado, carry, zero, overflow, negativo}); end
  endtask

  task automatic test_logic();
    logic [2:0] ops [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111};
    logic [3:0] exp [5] = '{4'b0010, 4'b1110, 4'b0101, 4'b1101, 4'b1100};
    int lat; logic ba;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], 4'b1010, 4'b0110, lat, ba);
      checks++; if (lat != 1 || resultado !== exp[i]) begin fails++;
        $display("FAIL logic_op%0d: got res %b lat %0d want %b lat 1", ops[i], resultado, lat,
                 exp[i]); end
      checks++; if ({carry, overflow, op_invalida, resultado_alto} !== 7'b0) begin fails++;
        $display("FAIL logic_flags_op%0d: got c/v/inv/hi %b want 0000000", ops[i],
                 {carry, overflow, op_invalida, resultado_alto}); end
    end
  endtask

  task automatic test_hold();
    logic [3:0] r0;
    r0 = resultado;  // XOR result 1100 from test_logic
    @(negedge clk); A = 4'hF; B = 4'h0; seletor = 3'b100;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (resultado !== 4'b1100 || done !== 1'b0 || busy !== 1'b0) begin fails++;
      $display("FAIL hold: got res %b done %b busy %b want 1100 0 0 (prev %b)", resultado, done,
               busy, r0); end
  endtask

  task automatic test_back_to_back();
    int lat; logic ba;
    run_op(3'b001, 4'b1010, 4'b0110, lat, ba);  // OR -> 1110, done now visible
    seletor = 3'b111; A = 4'b0011; B = 4'b0101; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if ({busy, done} !== 2'b10 || resultado !== 4'b1110) begin fails++;
      $display("FAIL b2b_accept: got busy/done %b res %b want 10 1110", {busy, done},
               resultado); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b1 || resultado !== 4'b0110) begin fails++;
      $display("FAIL b2b_result: got done %b res %b want 1 0110", done, resultado); end
  endtask

`ifdef ULA_MUL_EN
  task automatic test_mul();
    int lat; logic ba;
    run_op(3'b110, 4'b1010, 4'b0110, lat, ba);
    checks++; if (lat != 4) begin fails++; $display("FAIL mul_latency: got %0d want 4", lat); end
    checks++; if ({resultado_alto, resultado, carry, zero, op_invalida} !== 11'b0011_1100_100)
      begin fails++; $display("FAIL mul1: got hi/res/c/z/inv %b want 00111100100",
                              {resultado_alto, resultado, carry, zero, op_invalida}); end
    run_op(3'b110, 4'b1111, 4'b0001, lat, ba);
    checks++; if ({resultado_alto, resultado, carry, negativo} !== 10'b0000_1111_01) begin
      fails++; $display("FAIL mul2: got hi/res/c/n %b want 0000111101",
                        {resultado_alto, resultado, carry, negativo}); end
  endtask

  task automatic test_mul_ignore_start();
    int lat;
    @(negedge clk); seletor = 3'b110; A = 4'b0011; B = 4'b0101; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 2) begin seletor = 3'b000; A = 4'hF; B = 4'hF; start = 1'b1; end
      if (i == 3) start = 1'b0;
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = i; break; end
    end
    checks++; if (lat != 4 || {resultado_alto, resultado} !== 8'h0F) begin fails++;
      $display("FAIL mul_ignore_start: got lat %0d prod %h want 4 0f", lat,
               {resultado_alto, resultado}); end
    @(posedge clk); #1;
    checks++; if ({busy, done} !== 2'b00) begin fails++;
      $display("FAIL mul_not_queued: got busy/done %b want 00", {busy, done}); end
  endtask

  task automatic test_mul_reset();
    logic seen;
    @(negedge clk); seletor = 3'b110; A = 4'b1010; B = 4'b0110; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    checks++; if ({resultado, resultado_alto, carry, zero, busy, done} !== 12'b0) begin fails++;
      $display("FAIL mul_reset_outputs: got %b want 0",
               {resultado, resultado_alto, carry, zero, busy, done}); end
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (done === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin fails++;
      $display("FAIL mul_reset_no_done: got done seen %b want 0", seen); end
  endtask
`else
  task automatic test_mul_disabled();
    int lat; logic ba;
    run_op(3'b110, 4'b1010, 4'b0110, lat, ba);
    checks++; if (lat != 1) begin fails++;
      $display("FAIL inv_latency: got %0d want 1", lat); end
    checks++; if ({op_invalida, zero, resultado, resultado_alto, carry, overflow, negativo}
                  !== 13'b11_0000_0000_000) begin fails++;
      $display("FAIL inv_outputs: got inv/z/res/hi/c/v/n %b want 1100000000000",
               {op_invalida, zero, resultado, resultado_alto, carry, overflow, negativo}); end
    run_op(3'b000, 4'b1010, 4'b0110, lat, ba);
    checks++; if (op_invalida !== 1'b0) begin fails++;
      $display("FAIL inv_cleared: got %b want 0", op_invalida); end
  endtask
`endif

  initial begin
    test_reset();
    test_soma_sub();
    test_logic();
    test_hold();
    test_back_to_back();
`ifdef ULA_MUL_EN
    test_mul();
    test_mul_ignore_start();
    test_mul_reset();
`else
    test_mul_disabled();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ula_seq.md
# ula_seq

Parametrised, registered successor to the 4-bit combinational ULA. It has N-bit operands, a start/busy/done handshake, status flags, and an optional multi-cycle shift-add multiplier. The block sits between an operand/control source (sequencer or bench) and the datapath that consumes `resultado` and the flags. Operands are captured on `start`, and results are held until the next operation completes.

## Interface
- `WIDTH`, default 8: operand and result width in bits; must be ≥ 2.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  synchronous reset, active-high.
- `start`  input  1  request; accepted only in IDLE.
- `A`  input  WIDTH  operand A; sampled on the accepting edge.
- `B`  input  WIDTH  operand B; sampled on the accepting edge.
- `seletor`  input  3  operation code; sampled on the accepting edge.
- `resultado`  output  WIDTH  result; low half of the product for MUL.
- `resultado_alto`  output  WIDTH  upper half of the product for MUL; 0 for all other operations.
- `zero`  output  1  result equals 0; for MUL, the full 2·WIDTH product equals 0.
- `negativo`  output  1  MSB of `resultado`.
- `carry`  output  1  SOMA: carry-out. SUB: borrow (A < B unsigned). MUL: `resultado_alto` ≠ 0. Other operations: 0.
- `overflow`  output  1  signed overflow for SOMA/SUB; 0 otherwise.
- `op_invalida`  output  1  code 110 issued with the multiplier compiled out.
- `busy`  output  1  operation in progress.
- `done`  output  1  one-cycle pulse; all outputs updated in the same cycle.

## Operation
- Operation codes:
  - 000 AND
  - 001 OR
  - 010 NOT A
  - 011 NAND
  - 100 SOMA (A+B)
  - 101 SUB (A−B, two's complement)
  - 110 MUL (unsigned A·B, 2·WIDTH result)
  - 111 XOR
- Sum and difference are truncated to WIDTH bits.
- States: IDLE, CALC, MUL.
- IDLE with `start`=1: latch A, B and `seletor`.
  - If the code is 110 and the multiplier is compiled in, go to MUL.
  - Otherwise go to CALC.
- IDLE with `start`=0: stay in IDLE.
- CALC: compute from the latched operands, write all result and flag outputs, pulse `done`, return to IDLE.
- MUL:
  - Shift-add over WIDTH iterations, one multiplier bit per cycle, LSB first, using a 2·WIDTH-bit accumulator and an iteration counter.
  - After the last iteration, write the outputs, pulse `done`, return to IDLE.
- `start` while busy is ignored; it is not queued.
- Changes on A, B or `seletor` while busy have no effect.
- Outputs hold their last values until the next `done`.
- `op_invalida` is rewritten at every `done`.
- `busy` = (state ≠ IDLE).

## Timing
- Reset: on an edge with `rst`=1, all outputs go to 0, state goes to IDLE, and the counter and accumulator clear.
  - `rst` overrides `start`.
  - Reset during CALC or MUL aborts the operation; no `done` is produced.
- Let t be the accepting edge.
  - `busy` is high from edge t.
  - Non-MUL operations: outputs and `done` update at edge t+1. Latency is 1; `busy` is high for 1 cycle.
  - MUL: outputs and `done` update at edge t+WIDTH; `busy` is high for WIDTH cycles.
- `done` lasts exactly one cycle, and `busy` is low during it.
- A `start` present in the `done` cycle is accepted (back-to-back operation).
  - Issue rate is 1 operation per 2 cycles for single-cycle ops.

## Configuration
- Macro: `ULA_MUL_EN`.
- Defined:
  - Code 110 runs the multi-cycle multiplier described above.
  - `op_invalida` is always 0.
- Undefined:
  - No MUL state, accumulator or counter is synthesised.
  - Code 110 goes through CALC with 1-cycle latency and produces `resultado`=0, `resultado_alto`=0, `zero`=1, other flags 0, `op_invalida`=1.

## Test plan
All scenarios run with WIDTH=4.
- Reset:
  - Hold `rst` for 2 cycles -> all outputs 0.
  - Start plus reset on the same edge -> no `busy`, no `done`.
- SOMA and SUB with A=1010, B=0110:
  - SOMA -> `resultado`=0000, `carry`=1, `zero`=1, `overflow`=0.
  - SUB -> 0100, `carry`=0, `overflow`=1.
  - Each with `done` 1 cycle after acceptance.
- SUB with A=0011, B=1101 -> `resultado`=0110, `carry`=1, `overflow`=0, `negativo`=0.
- All logic codes on A=1010, B=0110:
  - AND -> 0010
  - OR -> 1110
  - NOT A -> 0101
  - NAND -> 1101
  - XOR -> 1100
  - `carry`/`overflow` = 0 for all.
- MUL with `ULA_MUL_EN` defined:
  - 1010·0110 -> `resultado`=1100, `resultado_alto`=0011, `carry`=1, `done` exactly 4 cycles after acceptance.
  - 1111·0001 -> 1111 / 0000, `carry`=0.
  - Second `start` mid-MUL -> ignored.
  - Reset mid-MUL -> outputs 0, no `done`.
- `ULA_MUL_EN` undefined: code 110 -> `op_invalida`=1, `zero`=1, `resultado`=0, `done` 1 cycle after acceptance.
